// File: rtl/lb_scheduler.sv
// lb_scheduler: sequences the two-bank scanline buffer between the PPU pixel
// stream and the VGA driver. Writes each PPU line into one bank while the VGA
// side reads the other, launches the VGA frame one PPU line behind the writer,
// and watches every completed line for drift and bank collisions.
module lb_scheduler #(
    parameter int LINE_W      = 256,
    parameter int FRAME_LINES = 240,
    parameter int DRIFT_CNT_W = 8
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   ppu_frame_start,
    input  logic                   pix_valid,
    input  logic [14:0]            pix,
    input  logic [9:0]             vga_vcounter,
    output logic                   wr_en,
    output logic [8:0]             wr_addr,
    output logic [14:0]            wr_data,
    output logic                   rd_bank,
    output logic                   vga_sync,
    output logic                   locked,
    output logic                   overrun,
    output logic [DRIFT_CNT_W-1:0] drift_count
);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_PRIME  = 2'd1,
        S_RUN    = 2'd2,
        S_RESYNC = 2'd3
    } state_t;

    localparam logic [7:0]             X_LAST    = 8'(LINE_W - 1);
    localparam logic [8:0]             LY_MAX    = 9'd511;
    localparam logic [9:0]             FRAME_END = 10'(FRAME_LINES);
    localparam logic [DRIFT_CNT_W-1:0] DRIFT_MAX = {DRIFT_CNT_W{1'b1}};

    state_t     state_r;
    state_t     state_nxt_s;
    logic [7:0] wr_x_r;
    logic       wr_bank_r;
    logic [8:0] ly_r;

    logic       line_done_s;
    logic [9:0] q_s;
    logic [9:0] ly_ext_s;
    logic       in_window_s;
    logic       aligned_s;
    logic       drift_s;
    logic       collision_s;
    logic       sync_nxt_s;
    logic       locked_nxt_s;
    logic       drift_inc_s;

    // A frame start resets the write position, so it masks a coincident line end.
    assign line_done_s = pix_valid & ~ppu_frame_start & (wr_x_r == X_LAST);

    // VGA shows each PPU line twice, so the VGA line pair index is vcounter/2.
    assign q_s         = vga_vcounter >> 1;
    assign ly_ext_s    = {1'b0, ly_r};
    assign in_window_s = (ly_r != 9'd0) && (ly_ext_s < FRAME_END);
    assign aligned_s   = (q_s == ly_ext_s) || (q_s == (ly_ext_s - 10'd1));
    assign drift_s     = (state_r == S_RUN) && line_done_s && in_window_s && !aligned_s;

    // A write landing in the bank currently being scanned out is a collision.
    assign collision_s = (state_r == S_RUN) && wr_en && (wr_addr[8] == rd_bank);

    // Line-buffer write port: one-cycle registered copy of the pixel strobe.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_en   <= 1'b0;
            wr_addr <= 9'd0;
            wr_data <= 15'd0;
        end else begin
            wr_en <= pix_valid;
            if (pix_valid) begin
                wr_addr <= ppu_frame_start ? 9'd0 : {wr_bank_r, wr_x_r};
                wr_data <= pix;
            end
        end
    end

    // Write position: pixel column, ping-pong bank and PPU line number.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_x_r    <= 8'd0;
            wr_bank_r <= 1'b0;
            ly_r      <= 9'd0;
        end else if (ppu_frame_start) begin
            wr_x_r    <= pix_valid ? 8'd1 : 8'd0;
            wr_bank_r <= 1'b0;
            ly_r      <= 9'd0;
        end else if (line_done_s) begin
            wr_x_r    <= 8'd0;
            wr_bank_r <= ~wr_bank_r;
            ly_r      <= (ly_r == LY_MAX) ? LY_MAX : (ly_r + 9'd1);
        end else if (pix_valid) begin
            wr_x_r <= wr_x_r + 8'd1;
        end
    end

    // Read bank follows VGA line bit 1: VGA lines 2L and 2L+1 read bank L&1.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rd_bank <= 1'b0;
        end else begin
            rd_bank <= vga_vcounter[1];
        end
    end

    // FSM state register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_r <= S_IDLE;
        end else begin
            state_r <= state_nxt_s;
        end
    end

    // Next-state logic plus the sync, lock and drift decisions.
    always_comb begin
        state_nxt_s  = state_r;
        sync_nxt_s   = 1'b0;
        locked_nxt_s = locked;
        drift_inc_s  = 1'b0;
        case (state_r)
            S_IDLE: begin
                locked_nxt_s = 1'b0;
                if (ppu_frame_start) begin
                    state_nxt_s = S_PRIME;
                end else begin
                    state_nxt_s = S_IDLE;
                end
            end
            S_PRIME: begin
                if (ppu_frame_start) begin
                    state_nxt_s = S_PRIME;
                end else if (line_done_s) begin
                    state_nxt_s  = S_RUN;
                    sync_nxt_s   = 1'b1;
                    locked_nxt_s = 1'b1;
                end else begin
                    state_nxt_s = S_PRIME;
                end
            end
            S_RUN: begin
                if (drift_s) begin
                    drift_inc_s  = 1'b1;
                    locked_nxt_s = 1'b0;
                    state_nxt_s  = ppu_frame_start ? S_PRIME : S_RESYNC;
                end else if (ppu_frame_start) begin
                    state_nxt_s = S_PRIME;
                end else begin
                    state_nxt_s = S_RUN;
                end
            end
            S_RESYNC: begin
                locked_nxt_s = 1'b0;
                if (ppu_frame_start) begin
                    state_nxt_s = S_PRIME;
                end else begin
                    state_nxt_s = S_RESYNC;
                end
            end
            default: begin
                state_nxt_s  = S_IDLE;
                locked_nxt_s = 1'b0;
            end
        endcase
    end

    // Status outputs: sync pulse, lock, sticky overrun, saturating drift count.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            vga_sync    <= 1'b0;
            locked      <= 1'b0;
            overrun     <= 1'b0;
            drift_count <= '0;
        end else begin
            vga_sync <= sync_nxt_s;
            locked   <= locked_nxt_s;
            overrun  <= overrun | collision_s;
            if (drift_inc_s && (drift_count != DRIFT_MAX)) begin
                drift_count <= drift_count + DRIFT_CNT_W'(1);
            end
        end
    end

endmodule

// File: doc/lb_scheduler.md
Name: lb_scheduler

Overview:
- Sequences the two-bank scanline buffer that sits between the PPU pixel stream and the VGA driver.
- Turns 256-pixel PPU lines into line-buffer writes and ping-pongs the write bank.
- Pulses the VGA driver's sync input so each VGA frame starts one PPU line behind the writer.
- Checks every completed line for VGA/PPU drift and for bank collisions. Drift drops lock until the next PPU frame; a collision sets a sticky overrun flag.

Parameters:
- LINE_W, 256: PPU pixels per line; wr_x wraps at LINE_W-1.
- FRAME_LINES, 240: visible PPU lines; drift checks apply only to lines below this.
- DRIFT_CNT_W, 8: width of the saturating drift counter.

Ports:
- clk  in  1  system clock
- reset  in  1  asynchronous, active-high reset
- ppu_frame_start  in  1  one-cycle pulse; first pixel of a PPU frame follows (or coincides)
- pix_valid  in  1  PPU pixel strobe
- pix  in  15  RGB555 pixel
- vga_vcounter  in  10  current VGA line from the VGA driver
- wr_en  out  1  line-buffer write enable
- wr_addr  out  9  {wr_bank, wr_x[7:0]}
- wr_data  out  15  pixel to write
- rd_bank  out  1  bank the VGA side reads; equals registered vga_vcounter[1]
- vga_sync  out  1  one-cycle frame-align pulse to the VGA driver
- locked  out  1  VGA/PPU alignment valid
- overrun  out  1  sticky bank-collision flag
- drift_count  out  DRIFT_CNT_W  saturating count of drift events

Behaviour:
Reset (async): all outputs 0; wr_x=0, wr_bank=0, ly=0; FSM=S_IDLE.

Write path (all FSM states):
- pix_valid at cycle n gives wr_en=1 at n+1, with wr_addr={wr_bank,wr_x} and wr_data=pix sampled at n.
- A valid pixel with wr_x==LINE_W-1 completes the line: wr_x<=0, wr_bank toggles, ly<=ly+1. ly saturates at 511.
- ppu_frame_start forces wr_x=0, wr_bank=0, ly=0.
  - If pix_valid is high in the same cycle, that pixel is written at bank 0, x 0, and wr_x becomes 1.
  - ppu_frame_start takes priority over a simultaneous line completion.

rd_bank: registered copy of vga_vcounter[1]. Each PPU line is shown on two VGA lines: VGA lines 2L and 2L+1 read bank L&1.

FSM:
- S_IDLE: locked=0. On ppu_frame_start go to S_PRIME.
- S_PRIME: waits for completion of PPU line 0.
  - On completion, vga_sync=1 in the next cycle only, then go to S_RUN.
  - Entering S_RUN sets locked=1.
- S_RUN: on each line completion of line L, with 1 <= L < FRAME_LINES:
  - Let q = vga_vcounter[9:1], sampled in the completion cycle.
  - q in {L-1, L} is OK.
  - Otherwise: drift_count+1 (saturating at all-ones), locked<=0, go to S_RESYNC.
  - On ppu_frame_start go to S_PRIME; locked stays 1, so each frame realigns.
- S_RESYNC: locked=0. On ppu_frame_start go to S_PRIME.
- Simultaneous ppu_frame_start and a drift event in S_RUN: the drift is counted and the FSM goes to S_PRIME.

Overrun:
- In S_RUN only, any cycle with wr_en=1 and wr_addr[8]==rd_bank sets overrun=1.
- overrun is cleared only by reset.

Mid-operation reset: the write in flight is dropped (wr_en=0 at once), and no vga_sync is emitted until a fresh frame has been primed.

vga_sync is never high for two consecutive cycles.

Test Plan:
- Reset, then 256 pix_valid cycles after ppu_frame_start -> wr_addr runs 0x000..0x0FF with wr_en one cycle after each pix_valid; vga_sync pulses exactly once, one cycle after the 256th pixel; locked=1; next pixel writes to address 0x100.
- Aligned run: vga_vcounter tracks 2*L-1 at each completion of lines 1..239 -> locked stays 1, drift_count=0, overrun=0.
- Drift: at completion of line 10, vga_vcounter=40 (q=20) -> drift_count=1, locked=0; next ppu_frame_start plus line 0 completion -> vga_sync pulse, locked=1.
- Collision: in S_RUN, hold vga_vcounter=2 (rd_bank=1) while writing line 1 (bank 1) -> overrun=1 one cycle after the first colliding wr_en; it stays set through a later frame; reset clears it.
- Boundaries:
  - ppu_frame_start coincident with pix_valid at wr_x=255 -> pixel written at address 0x000, wr_x=1, ly=0, no line completion.
  - reset asserted mid-line -> all outputs 0 immediately; FSM=S_IDLE.
- Saturation: force 300 drift events -> drift_count holds 255.
